// File: rtl/grid_pkg.sv
// Shared types and helpers for the grid input latch.
package grid_pkg;

  localparam int GRID_CELLS = 16;

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    OFFER = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [3:0] lsb_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = GRID_CELLS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces the 16-bit key vector with one shared counter and reports new presses.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] scan_data,
  input  logic        scan_valid,
  output logic [15:0] stable,
  output logic [15:0] rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [15:0]      sample_s;
  logic [15:0]      last_r;
  logic [CNT_W-1:0] cnt_r;

  // An unqualified vector reads as "no key pressed".
  always_comb begin
    if (scan_valid) begin
      sample_s = scan_data;
    end else begin
      sample_s = 16'h0000;
    end
  end

  // Any change restarts the settle window; the vector is accepted once, when the count first hits the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 16'h0000;
      cnt_r  <= {CNT_W{1'b0}};
      stable <= 16'h0000;
      rise   <= 16'h0000;
    end else begin
      last_r <= sample_s;
      rise   <= 16'h0000;
      if (sample_s != last_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_ONE;
        if (cnt_r == CNT_MAX - CNT_ONE) begin
          stable <= last_r;
          rise   <= last_r & ~stable;
        end
      end
    end
  end

endmodule

// File: rtl/grid_input_latch.sv
// Key-driven 4x4 drawing grid that freezes its image and hands it to the classifier.
import grid_pkg::*;

module grid_input_latch #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] scan_data,
  input  logic        scan_valid,
  input  logic        clear_req,
  input  logic        submit_req,
  input  logic        img_ready,
  input  logic        mlp_done,
  output logic [15:0] grid,
  output logic [15:0] img_data,
  output logic        img_valid,
  output logic        key_event,
  output logic [3:0]  key_index,
  output logic        busy
);

  state_t      state;
  logic [15:0] stable_s;
  logic [15:0] rise_s;
  logic [15:0] press_s;
  logic [15:0] edit_grid_s;
  logic        toggle_s;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_key_debounce (
    .clk        (clk),
    .rst        (rst),
    .scan_data  (scan_data),
    .scan_valid (scan_valid),
    .stable     (stable_s),
    .rise       (rise_s)
  );

  // Grid value an EDIT cycle would produce: clear wins, otherwise every newly pressed cell flips.
  // A genuine press is always part of the accepted vector, so masking with it drops any stray bit.
  always_comb begin
    press_s = rise_s & stable_s;
    if (clear_req) begin
      edit_grid_s = 16'h0000;
      toggle_s    = 1'b0;
    end else begin
      edit_grid_s = grid ^ press_s;
      toggle_s    = (press_s != 16'h0000);
    end
  end

  // Edit/offer/hold sequencing with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EDIT;
      grid      <= 16'h0000;
      img_data  <= 16'h0000;
      img_valid <= 1'b0;
      key_event <= 1'b0;
      key_index <= 4'd0;
      busy      <= 1'b0;
    end else begin
      key_event <= 1'b0;
      case (state)
        EDIT: begin
          grid <= edit_grid_s;
          if (toggle_s) begin
            key_event <= 1'b1;
            key_index <= lsb_index(press_s);
          end
          if (submit_req) begin
            img_data  <= edit_grid_s;
            img_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (img_valid && img_ready) begin
            img_valid <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (mlp_done) begin
            busy  <= 1'b0;
            state <= EDIT;
          end
        end
        default: begin
          img_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= EDIT;
        end
      endcase
    end
  end

endmodule
